// File: rtl/mux_rr_scheduler.sv
// Round-robin control stage for a 4:1 data mux: arbitrates four requesters, drives the
// mux select, captures the selected data and hands it downstream on valid/ready.
module mux_rr_scheduler #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] mux_out,
   output logic [1:0]       sel,
   output logic [3:0]       gnt,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_ch,
   output logic             out_valid,
   input  logic             out_ready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SELECT = 2'd1,
      OUTPUT = 2'd2
   } state_t;

   state_t           state_reg;
   logic [1:0]       ptr_reg;
   logic [1:0]       sel_reg;
   logic [WIDTH-1:0] data_reg;
   logic [1:0]       ch_reg;
   logic             valid_reg;

   logic [3:0]       rot_req;
   logic [1:0]       offset;
   logic [1:0]       winner;
   logic             handshake;

   // Rotate requests so that bit 0 is the current highest-priority channel.
   for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      assign rot_req[gi] = req[ptr_reg + 2'(gi)];
   end

   always_comb begin
      offset = 2'd0;
      if (rot_req[0])
         offset = 2'd0;
      else if (rot_req[1])
         offset = 2'd1;
      else if (rot_req[2])
         offset = 2'd2;
      else
         offset = 2'd3;
   end

   assign winner    = ptr_reg + offset;
   assign handshake = valid_reg && out_ready;

   // Grant is a combinational one-hot pulse during the accepted cycle only.
   for (genvar gi = 0; gi < 4; gi++) begin : g_gnt
      assign gnt[gi] = handshake && (ch_reg == 2'(gi));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         ptr_reg   <= 2'd0;
         sel_reg   <= 2'd0;
         data_reg  <= '0;
         ch_reg    <= 2'd0;
         valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (|req) begin
                  sel_reg   <= winner;
                  state_reg <= SELECT;
               end
            end
            SELECT: begin
               // The mux has had a full cycle to settle on sel_reg.
               data_reg  <= mux_out;
               ch_reg    <= sel_reg;
               valid_reg <= 1'b1;
               state_reg <= OUTPUT;
            end
            OUTPUT: begin
               if (out_ready) begin
                  valid_reg <= 1'b0;
                  ptr_reg   <= ch_reg + 2'd1;
                  state_reg <= IDLE;
               end
            end
            default: begin
               valid_reg <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign sel       = sel_reg;
   assign out_data  = data_reg;
   assign out_ch    = ch_reg;
   assign out_valid = valid_reg;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Bench for mux_rr_scheduler: models the 4:1 mux around the DUT and checks every
// downstream transfer against expectations queued when the request is driven.
module tb_mux_rr_scheduler;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst_n;
   logic [3:0]       req;
   logic [WIDTH-1:0] mux_out;
   logic [1:0]       sel;
   logic [3:0]       gnt;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       out_ch;
   logic             out_valid;
   logic             out_ready;

   logic [WIDTH-1:0] mux_in [4];
   int               cycle;
   int               tests;
   int               failed;

   typedef struct packed {
      logic [1:0]       ch;
      logic [WIDTH-1:0] data;
   } exp_t;

   typedef struct {
      logic [3:0]  req;
      logic [15:0] data;
      logic [1:0]  ch;
      logic [3:0]  dout;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[9];

   mux_rr_scheduler #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .mux_out   (mux_out),
      .sel       (sel),
      .gnt       (gnt),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   // Behavioural 4:1 mux, purely combinational on sel.
   assign mux_out = mux_in[sel];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic set_data(input logic [15:0] d);
      for (int i = 0; i < 4; i++) mux_in[i] = d[4*i +: 4];
   endtask

   task automatic push_exp(input logic [1:0] ch, input logic [WIDTH-1:0] data);
      exp_t e;
      e.ch   = ch;
      e.data = data;
      sb_q.push_back(e);
   endtask

   // Compare the transfer visible right now against the oldest queued expectation.
   task automatic check_xfer(input string name);
      exp_t e;
      if (sb_q.size() == 0) begin
         tests++;
         failed++;
         $display("FAIL %s: transfer ch=%0d with empty scoreboard", name, out_ch);
      end else begin
         e = sb_q.pop_front();
         check({name, "_valid"}, {31'd0, out_valid && out_ready}, 32'd1);
         check({name, "_ch"},   32'(out_ch),   32'(e.ch));
         check({name, "_data"}, 32'(out_data), 32'(e.data));
         check({name, "_gnt"},  32'(gnt),      32'(4'b0001 << e.ch));
         $display("[TB] %s: xfer ch=%0d data=%0h gnt=%b", name, out_ch, out_data, gnt);
      end
   endtask

   task automatic wait_xfer(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (out_valid && out_ready) seen = 1'b1;
      end
      if (seen) begin
         check_xfer(name);
      end else begin
         tests++;
         failed++;
         $display("FAIL %s: no handshake within 20 cycles, got none, required one", name);
         if (sb_q.size() > 0) void'(sb_q.pop_front());
      end
   endtask

   task automatic wait_valid(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check({name, "_wait_valid"}, {31'd0, seen}, 32'd1);
   endtask

   initial begin
      int c0;
      int prev;
      tests     = 0;
      failed    = 0;
      cycle     = 0;
      rst_n     = 1'b0;
      req       = 4'hF;
      out_ready = 1'b0;
      set_data(16'h4321);

      // Channel pointer is 0 after reset; the table relies on the pointer
      // left by the single-request test (ch2 -> ptr 3).
      vecs[0] = '{req: 4'b1001, data: 16'h4321, ch: 2'd3, dout: 4'h4};
      vecs[1] = '{req: 4'b1001, data: 16'h9876, ch: 2'd0, dout: 4'h6};
      vecs[2] = '{req: 4'b1001, data: 16'h9876, ch: 2'd3, dout: 4'h9};
      vecs[3] = '{req: 4'b0110, data: 16'h5A3C, ch: 2'd1, dout: 4'h3};
      vecs[4] = '{req: 4'b0011, data: 16'h5A3C, ch: 2'd0, dout: 4'hC};
      vecs[5] = '{req: 4'b0001, data: 16'h5A3C, ch: 2'd0, dout: 4'hC};
      vecs[6] = '{req: 4'b1000, data: 16'hF0E1, ch: 2'd3, dout: 4'hF};
      vecs[7] = '{req: 4'b1110, data: 16'hF0E1, ch: 2'd1, dout: 4'hE};
      vecs[8] = '{req: 4'b1010, data: 16'hF0E1, ch: 2'd3, dout: 4'hF};

      // Reset held with all requests active.
      @(negedge clk);
      @(negedge clk);
      check("rst_sel",   32'(sel),       32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_gnt",   32'(gnt),       32'd0);
      check("rst_data",  32'(out_data),  32'd0);
      check("rst_ch",    32'(out_ch),    32'd0);
      rst_n = 1'b1;

      // Single request on channel 2: latency and one-cycle grant.
      req       = 4'b0100;
      out_ready = 1'b1;
      c0        = cycle;
      push_exp(2'd2, 4'h3);
      @(negedge clk);
      check("single_sel",    32'(sel),       32'd2);
      check("single_nvalid", 32'(out_valid), 32'd0);
      wait_xfer("single");
      check("single_latency", 32'(cycle - c0), 32'd2);
      req = 4'b0000;
      @(negedge clk);
      check("single_gnt_off", 32'(gnt),       32'd0);
      check("single_vld_off", 32'(out_valid), 32'd0);

      // Table of isolated requests exercising pointer rotation and wrap.
      for (int i = 0; i < 9; i++) begin
         set_data(vecs[i].data);
         req = vecs[i].req;
         push_exp(vecs[i].ch, vecs[i].dout);
         wait_xfer($sformatf("vec%0d", i));
         req = 4'b0000;
         @(negedge clk);
      end

      // Fairness: all requests held, pointer at 0.
      set_data(16'h4321);
      req  = 4'hF;
      prev = 0;
      for (int k = 0; k < 5; k++) begin
         push_exp(2'(k % 4), 4'(k % 4 + 1));
         wait_xfer($sformatf("fair%0d", k));
         if (k > 0) check($sformatf("fair_gap%0d", k), 32'(cycle - prev), 32'd3);
         prev = cycle;
      end
      req = 4'b0000;
      @(negedge clk);

      // Reset during OUTPUT with backpressure; pointer is 1 beforehand.
      req       = 4'b0010;
      out_ready = 1'b0;
      wait_valid("mid");
      rst_n = 1'b0;
      req   = 4'b0000;
      #1;
      check("mid_gnt0", 32'(gnt), 32'd0);
      @(negedge clk);
      check("mid_valid", 32'(out_valid), 32'd0);
      check("mid_sel",   32'(sel),       32'd0);
      check("mid_gnt1",  32'(gnt),       32'd0);
      req       = 4'b0011;
      out_ready = 1'b1;
      #1;
      check("mid_gnt2", 32'(gnt), 32'd0);
      @(negedge clk);
      check("mid_gnt3", 32'(gnt), 32'd0);
      rst_n = 1'b1;
      push_exp(2'd0, 4'h1);
      wait_xfer("mid_first");
      req = 4'b0000;
      @(negedge clk);

      // Backpressure: output held while the mux input changes underneath it.
      set_data(16'h4321);
      req       = 4'b0100;
      out_ready = 1'b0;
      push_exp(2'd2, 4'h3);
      wait_valid("bp");
      req = 4'b0000;
      set_data(16'h8765);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("bp_data%0d", k),  32'(out_data),  32'h3);
         check($sformatf("bp_ch%0d", k),    32'(out_ch),    32'd2);
         check($sformatf("bp_sel%0d", k),   32'(sel),       32'd2);
         check($sformatf("bp_gnt%0d", k),   32'(gnt),       32'd0);
         check($sformatf("bp_valid%0d", k), 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      #1;
      check_xfer("bp_release");
      @(negedge clk);
      check("bp_gnt_off", 32'(gnt),       32'd0);
      check("bp_vld_off", 32'(out_valid), 32'd0);

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
